// File: rtl/pong_game_controller.sv
// Pong game sequencer: paddles, ball, scores and the serve/play/over state,
// all advanced once per frame_tick so the picture never changes mid-frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; ball centred, paddles frozen, waiting for start
// S_SERVE | ball held centred for SERVE_FRAMES ticks, paddles move
// S_PLAY  | ball moves, walls bounce, paddles hit, edges score
// S_OVER  | a player reached SCORE_MAX; everything frozen until start
module pong_game_controller #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PAD_DISTANCE  = 16,
    parameter int PAD_WIDTH     = 8,
    parameter int PAD_HEIGHT    = 64,
    parameter int BALL_SIZE     = 8,
    parameter int PAD_SPEED     = 4,
    parameter int BALL_SPEED    = 2,
    parameter int SERVE_FRAMES  = 60,
    parameter int SCORE_MAX     = 9
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    output logic [8:0] pad_left,
    output logic [8:0] pad_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] game_state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES);

    localparam logic signed [10:0] ZERO    = 11'sd0;
    localparam logic signed [10:0] HALF    = 11'(BALL_SIZE / 2);
    localparam logic signed [10:0] FL_X    = 11'(PAD_DISTANCE + PAD_WIDTH);
    localparam logic signed [10:0] FR_X    = 11'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
    localparam logic signed [10:0] X_LAST  = 11'(SCREEN_WIDTH - 1);
    localparam logic signed [10:0] Y_LAST  = 11'(SCREEN_HEIGHT - 1);
    localparam logic signed [10:0] PAD_MIN = 11'(PAD_HEIGHT / 2);
    localparam logic signed [10:0] PAD_MAX = 11'(SCREEN_HEIGHT - 1 - PAD_HEIGHT / 2);
    localparam logic signed [10:0] REACH   = 11'((PAD_HEIGHT + BALL_SIZE) / 2);
    localparam logic signed [10:0] P_SPD   = 11'(PAD_SPEED);
    localparam logic signed [10:0] B_SPD   = 11'(BALL_SPEED);

    localparam logic [9:0]    X_MID    = 10'(SCREEN_WIDTH / 2);
    localparam logic [8:0]    Y_MID    = 9'(SCREEN_HEIGHT / 2);
    localparam logic [3:0]    S_MAX    = 4'(SCORE_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

    state_t        state, state_n;
    logic [8:0]    pad_l, pad_l_n, pad_r, pad_r_n;
    logic [9:0]    bx, bx_n;
    logic [8:0]    by, by_n;
    logic          dx, dx_n, dy, dy_n;     // 1 = right / down
    logic [3:0]    sl, sl_n, sr, sr_n;
    logic [CW-1:0] cnt, cnt_n;

    logic signed [10:0] bxs, bys, nx_raw, nx, ny_raw, ny, dist_l, dist_r;
    logic               dy_b, hit_l, hit_r, point_l, point_r;
    logic [8:0]         pad_l_mv, pad_r_mv;
    logic [3:0]         sl_inc, sr_inc;

    // One paddle step with clamping; both or neither button means no move.
    function automatic logic [8:0] pad_step(input logic [8:0] y, input logic up, input logic dn);
        logic signed [10:0] t;
        t = $signed({2'b00, y});
        if (up && !dn) begin
            t = t - P_SPD;
            if (t < PAD_MIN) t = PAD_MIN;
        end else if (dn && !up) begin
            t = t + P_SPD;
            if (t > PAD_MAX) t = PAD_MAX;
        end
        return 9'(t);
    endfunction

    // Collision and movement candidates, all from pre-update positions.
    always_comb begin
        bxs    = $signed({1'b0, bx});
        bys    = $signed({2'b00, by});
        ny_raw = dy ? (bys + B_SPD) : (bys - B_SPD);
        ny     = ny_raw;
        dy_b   = dy;
        if (ny_raw - HALF < ZERO) begin
            ny   = HALF;
            dy_b = 1'b1;
        end else if (ny_raw + HALF > Y_LAST) begin
            ny   = Y_LAST - HALF;
            dy_b = 1'b0;
        end
        nx_raw = dx ? (bxs + B_SPD) : (bxs - B_SPD);
        dist_l = bys - $signed({2'b00, pad_l});
        dist_r = bys - $signed({2'b00, pad_r});
        if (dist_l < ZERO) dist_l = -dist_l;
        if (dist_r < ZERO) dist_r = -dist_r;
        hit_l   = !dx && (nx_raw - HALF <= FL_X) && (bxs - HALF > FL_X) && (dist_l < REACH);
        hit_r   = dx && (nx_raw + HALF >= FR_X) && (bxs + HALF < FR_X) && (dist_r < REACH);
        point_r = !dx && !hit_l && (nx_raw - HALF <= ZERO);
        point_l = dx && !hit_r && (nx_raw + HALF >= X_LAST);
        nx      = hit_l ? (FL_X + HALF) : (hit_r ? (FR_X - HALF) : nx_raw);
        pad_l_mv = pad_step(pad_l, btn_l_up, btn_l_dn);
        pad_r_mv = pad_step(pad_r, btn_r_up, btn_r_dn);
        sl_inc   = sl + 4'd1;
        sr_inc   = sr + 4'd1;
    end

    // Next-state and next-value selection; nothing changes without a tick.
    always_comb begin
        state_n = state;
        pad_l_n = pad_l;
        pad_r_n = pad_r;
        bx_n    = bx;
        by_n    = by;
        dx_n    = dx;
        dy_n    = dy;
        sl_n    = sl;
        sr_n    = sr;
        cnt_n   = cnt;
        if (frame_tick) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_SERVE;
                        cnt_n   = '0;
                    end
                end
                S_SERVE: begin
                    pad_l_n = pad_l_mv;
                    pad_r_n = pad_r_mv;
                    bx_n    = X_MID;
                    by_n    = Y_MID;
                    if (cnt == CNT_LAST) state_n = S_PLAY;
                    else                 cnt_n   = cnt + CW'(1);
                end
                S_PLAY: begin
                    pad_l_n = pad_l_mv;
                    pad_r_n = pad_r_mv;
                    if (point_l || point_r) begin
                        bx_n = X_MID;
                        by_n = Y_MID;
                        // Serve goes toward whoever conceded; dy is kept.
                        if (point_r) begin
                            sr_n = sr_inc;
                            dx_n = 1'b0;
                        end else begin
                            sl_n = sl_inc;
                            dx_n = 1'b1;
                        end
                        if ((point_r && sr_inc == S_MAX) || (point_l && sl_inc == S_MAX)) begin
                            state_n = S_OVER;
                        end else begin
                            state_n = S_SERVE;
                            cnt_n   = '0;
                        end
                    end else begin
                        bx_n = 10'(nx);
                        by_n = 9'(ny);
                        dy_n = dy_b;
                        if (hit_l)      dx_n = 1'b1;
                        else if (hit_r) dx_n = 1'b0;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        sl_n    = '0;
                        sr_n    = '0;
                        state_n = S_SERVE;
                        cnt_n   = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Game state registers with synchronous active-low reset.
    always_ff @(posedge clk_vga) begin
        if (!rst) begin
            state <= S_IDLE;
            pad_l <= Y_MID;
            pad_r <= Y_MID;
            bx    <= X_MID;
            by    <= Y_MID;
            dx    <= 1'b1;
            dy    <= 1'b1;
            sl    <= '0;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pad_l <= pad_l_n;
            pad_r <= pad_r_n;
            bx    <= bx_n;
            by    <= by_n;
            dx    <= dx_n;
            dy    <= dy_n;
            sl    <= sl_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
        end
    end

    assign pad_left    = pad_l;
    assign pad_right   = pad_r;
    assign ball_x      = bx;
    assign ball_y      = by;
    assign score_left  = sl;
    assign score_right = sr;
    assign game_state  = state;
    assign game_over   = (state == S_OVER);

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: a table of hand-written vectors, then long
// play sequences checked against a behavioural model through a scoreboard queue.
module tb_pong_game_controller;

    logic clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    logic       rst, frame_tick, start;
    logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
    logic [8:0] pad_left, pad_right, ball_y;
    logic [9:0] ball_x;
    logic [3:0] score_left, score_right;
    logic [1:0] game_state;
    logic       game_over;

    pong_game_controller dut (
        .clk_vga(clk_vga), .rst(rst), .frame_tick(frame_tick), .start(start),
        .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
        .pad_left(pad_left), .pad_right(pad_right), .ball_x(ball_x), .ball_y(ball_y),
        .score_left(score_left), .score_right(score_right),
        .game_state(game_state), .game_over(game_over)
    );

    typedef struct packed {
        logic [8:0] pl;
        logic [8:0] pr;
        logic [9:0] bx;
        logic [8:0] by;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] gs;
        logic       go;
    } exp_t;

    typedef struct {
        bit r, t, s, lu, ld, ru, rd;
        int pl, pr, gs;
    } vec_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    string tag   = "init";

    // behavioural model state
    int m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_gs, m_cnt;
    int hits_l = 0, hits_r = 0;

    function automatic int pad_move(int y, bit up, bit dn);
        if (up && !dn) return (y - 4 < 32) ? 32 : y - 4;
        if (dn && !up) return (y + 4 > 447) ? 447 : y + 4;
        return y;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.pl = 9'(m_pl);  e.pr = 9'(m_pr);
        e.bx = 10'(m_bx); e.by = 9'(m_by);
        e.sl = 4'(m_sl);  e.sr = 4'(m_sr);
        e.gs = 2'(m_gs);  e.go = (m_gs == 3);
        return e;
    endfunction

    task automatic model_update(input bit r, t, s, lu, ld, ru, rd);
        int nx, ny, ndx, ndy, npl, npr;
        bit pt_l, pt_r;
        if (!r) begin
            m_pl = 240; m_pr = 240; m_bx = 320; m_by = 240;
            m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_gs = 0; m_cnt = 0;
            return;
        end
        if (!t) return;
        npl = pad_move(m_pl, lu, ld);
        npr = pad_move(m_pr, ru, rd);
        case (m_gs)
            0: if (s) begin m_gs = 1; m_cnt = 0; end
            1: begin
                m_pl = npl; m_pr = npr; m_bx = 320; m_by = 240;
                if (m_cnt == 59) m_gs = 2; else m_cnt++;
            end
            2: begin
                ny = m_by + 2 * m_dy; ndy = m_dy;
                if (ny - 4 < 0) begin ny = 4; ndy = 1; end
                else if (ny + 4 > 479) begin ny = 475; ndy = -1; end
                nx = m_bx + 2 * m_dx; ndx = m_dx; pt_l = 0; pt_r = 0;
                if (m_dx < 0) begin
                    if (nx - 4 <= 24 && m_bx - 4 > 24 && iabs(m_by - m_pl) < 36) begin
                        nx = 28; ndx = 1; hits_l++;
                    end else if (nx - 4 <= 0) pt_r = 1;
                end else begin
                    if (nx + 4 >= 616 && m_bx + 4 < 616 && iabs(m_by - m_pr) < 36) begin
                        nx = 612; ndx = -1; hits_r++;
                    end else if (nx + 4 >= 639) pt_l = 1;
                end
                m_pl = npl; m_pr = npr;
                if (pt_l || pt_r) begin
                    if (pt_r) begin m_sr++; m_dx = -1; end
                    else      begin m_sl++; m_dx = 1;  end
                    m_bx = 320; m_by = 240;
                    if (m_sr == 9 || m_sl == 9) m_gs = 3;
                    else begin m_gs = 1; m_cnt = 0; end
                end else begin
                    m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
                end
            end
            default: if (s) begin m_sl = 0; m_sr = 0; m_gs = 1; m_cnt = 0; end
        endcase
    endtask

    // One clock: drive at negedge, push expectation, compare just after posedge.
    task automatic step(input bit r, t, s, lu, ld, ru, rd, input bit use_own, input exp_t own_e);
        exp_t e, a;
        @(negedge clk_vga);
        rst = r; frame_tick = t; start = s;
        btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
        model_update(r, t, s, lu, ld, ru, rd);
        sb_q.push_back(use_own ? own_e : model_exp());
        @(posedge clk_vga);
        #1;
        e = sb_q.pop_front();
        a = {pad_left, pad_right, ball_x, ball_y, score_left, score_right, game_state, game_over};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: actual pl=%0d pr=%0d bx=%0d by=%0d sl=%0d sr=%0d gs=%0d go=%0d required pl=%0d pr=%0d bx=%0d by=%0d sl=%0d sr=%0d gs=%0d go=%0d",
                     tag, a.pl, a.pr, a.bx, a.by, a.sl, a.sr, a.gs, a.go,
                     e.pl, e.pr, e.bx, e.by, e.sl, e.sr, e.gs, e.go);
        end
    endtask

    // A frame tick followed by a quiet cycle with random inputs that must be ignored.
    task automatic tick(input bit s, lu, ld, ru, rd);
        step(1'b1, 1'b1, s, lu, ld, ru, rd, 1'b0, '0);
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mkv(bit r, t, s, lu, ld, ru, rd, int pl, int pr, int gs);
        vec_t v;
        v.r = r; v.t = t; v.s = s; v.lu = lu; v.ld = ld; v.ru = ru; v.rd = rd;
        v.pl = pl; v.pr = pr; v.gs = gs;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        exp_t e;
        bit   lu, ld, ru, rd;
        int   n;

        rst = 1'b0; frame_tick = 1'b0; start = 1'b0;
        btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;

        //            r  t  s  lu ld ru rd  pl   pr   gs
        tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 240, 240, 0);
        tbl[1]  = mkv(1, 1, 0, 1, 0, 0, 0, 240, 240, 0);
        tbl[2]  = mkv(1, 0, 1, 0, 0, 0, 0, 240, 240, 0);
        tbl[3]  = mkv(1, 1, 1, 1, 0, 0, 0, 240, 240, 1);
        tbl[4]  = mkv(1, 1, 0, 1, 0, 0, 0, 236, 240, 1);
        tbl[5]  = mkv(1, 0, 0, 1, 0, 0, 0, 236, 240, 1);
        tbl[6]  = mkv(1, 1, 0, 1, 1, 0, 0, 236, 240, 1);
        tbl[7]  = mkv(1, 1, 0, 0, 0, 0, 1, 236, 244, 1);
        tbl[8]  = mkv(1, 1, 0, 0, 1, 1, 0, 240, 240, 1);
        tbl[9]  = mkv(1, 1, 1, 0, 0, 0, 0, 240, 240, 1);
        tbl[10] = mkv(1, 1, 0, 0, 1, 0, 1, 244, 244, 1);
        tbl[11] = mkv(0, 1, 1, 1, 0, 1, 0, 240, 240, 0);

        tag = "table";
        for (int i = 0; i < 12; i++) begin
            e = {9'(tbl[i].pl), 9'(tbl[i].pr), 10'd320, 9'd240, 4'd0, 4'd0,
                 2'(tbl[i].gs), tbl[i].gs == 3};
            step(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].lu, tbl[i].ld, tbl[i].ru, tbl[i].rd, 1'b1, e);
        end

        // Serve countdown with the left paddle driven into its top clamp.
        tag = "serve";
        tick(1'b1, 0, 0, 0, 0);
        check("start_to_serve", int'(game_state), 1);
        for (int k = 1; k <= 70; k++) begin
            tick(1'b0, 1, 0, 0, 0);
            if (k == 51) check("pad_l_k51", int'(pad_left), 36);
            if (k == 52) check("pad_l_k52", int'(pad_left), 32);
            if (k == 59) check("still_serve_k59", int'(game_state), 1);
            if (k == 60) begin
                check("play_k60", int'(game_state), 2);
                check("ball_x_k60", int'(ball_x), 320);
            end
            if (k == 61) begin
                check("ball_x_k61", int'(ball_x), 322);
                check("ball_y_k61", int'(ball_y), 242);
            end
        end
        check("pad_l_stuck", int'(pad_left), 32);
        for (int k = 0; k < 3; k++) tick(1'b0, 1, 1, 1, 1);
        check("both_btn_l", int'(pad_left), 32);
        check("both_btn_r", int'(pad_right), 240);

        // Rally: both paddles chase the ball.
        tag = "rally";
        for (int k = 0; k < 1500; k++) begin
            lu = m_pl > m_by + 2; ld = m_pl < m_by - 2;
            ru = m_pr > m_by + 2; rd = m_pr < m_by - 2;
            tick(1'b0, lu, ld, ru, rd);
        end
        $display("info: model hits left=%0d right=%0d", hits_l, hits_r);

        // Left paddle parked at the top; right keeps returning until game over.
        tag = "to_over";
        n = 0;
        while (m_gs != 3 && n < 20000) begin
            ru = m_pr > m_by + 2; rd = m_pr < m_by - 2;
            tick(1'b0, 1, 0, ru, rd);
            n++;
        end
        if (m_gs != 3) begin
            total++; bad++;
            $display("FAIL over_budget: actual ticks=%0d required game over within 20000", n);
        end
        check("over_flag", int'(game_over), 1);
        check("over_state", int'(game_state), 3);
        check("over_score_r", int'(score_right), 9);
        tag = "over_frozen";
        for (int k = 0; k < 5; k++) tick(1'b0, 0, 1, 0, 1);
        check("over_pad_l", int'(pad_left), 32);
        check("over_ball_x", int'(ball_x), 320);
        check("over_score_held", int'(score_right), 9);
        tag = "restart";
        tick(1'b1, 0, 0, 0, 0);
        check("restart_score_r", int'(score_right), 0);
        check("restart_state", int'(game_state), 1);

        // Back into play, then reset coincident with a frame tick.
        tag = "reset_play";
        for (int k = 0; k < 70; k++) tick(1'b0, 0, 1, 1, 0);
        check("replay_state", int'(game_state), 2);
        step(1'b0, 1'b1, 1'b1, 1, 0, 0, 1, 1'b0, '0);
        check("rst_state", int'(game_state), 0);
        check("rst_pad_l", int'(pad_left), 240);
        check("rst_pad_r", int'(pad_right), 240);
        check("rst_ball_x", int'(ball_x), 320);
        check("rst_ball_y", int'(ball_y), 240);
        tick(1'b0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
